// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch
//
// Instruction fetch stage feeding the SISC datapath/control top. It owns the
// fetch program counter, issues one instruction-memory read at a time, holds
// the returned word in an instruction register until the control unit
// accepts it, and then redirects the fetch PC if the accepted instruction
// turned out to be a taken branch. A HALT instruction parks the block until
// the next reset.
//
// Parameters
//   ADDR_W     width of the word-addressed PC and memory address
//   RESET_PC   PC value loaded on reset
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_f        in   synchronous active-high reset
//   imem_req     out  fetch request to instruction memory
//   imem_addr    out  word address of the request (the fetch PC)
//   imem_ack     in   read data valid this cycle
//   imem_rdata   in   instruction word from memory
//   ir           out  instruction register
//   ir_valid     out  ir holds an unconsumed instruction
//   ir_ready     in   downstream consumes ir this cycle
//   pc_out       out  address of the instruction currently in ir
//   br_taken     in   redirect for the instruction being consumed
//   br_rel       in   1 = PC-relative target, 0 = absolute target
//   br_imm       in   branch offset or absolute target
//   halt         in   the consumed instruction is HALT
// ---------------------------------------------------------------------------
module ifetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              br_taken,
    input  logic              br_rel,
    input  logic [15:0]       br_imm,
    input  logic              halt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    // Branch target arithmetic is done at a width that holds both the PC
    // and the 16-bit immediate, then truncated back to ADDR_W.
    localparam int EXT_W = (ADDR_W > 16) ? ADDR_W : 16;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] br_target;
    logic [EXT_W-1:0]  imm_sext;
    logic [EXT_W-1:0]  imm_zext;
    logic [EXT_W-1:0]  pc_ext;
    logic [EXT_W-1:0]  rel_sum;
    logic              accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; halt wins over a simultaneous branch
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FETCH;
            FETCH:   if (imem_ack) next_state = HOLD;
            HOLD:    if (ir_ready) next_state = halt ? HALTED : FETCH;
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    // Outputs that follow directly from the state
    always_comb begin
        imem_req = 1'b0;
        ir_valid = 1'b0;
        case (state)
            FETCH:   imem_req = 1'b1;
            HOLD:    ir_valid = 1'b1;
            default: begin
                imem_req = 1'b0;
                ir_valid = 1'b0;
            end
        endcase
    end

    assign imem_addr = fpc;
    assign accept    = (state == HOLD) && ir_ready;

    // Relative target is pc_out + 1 + sign-extended immediate; absolute
    // target is the zero-extended (or truncated) immediate.
    always_comb begin
        imm_sext  = EXT_W'($signed(br_imm));
        imm_zext  = EXT_W'(br_imm);
        pc_ext    = EXT_W'(pc_out);
        rel_sum   = pc_ext + EXT_W'(1) + imm_sext;
        br_target = br_rel ? rel_sum[ADDR_W-1:0] : imm_zext[ADDR_W-1:0];
    end

    // Fetch PC, instruction register and its address. Acks are only
    // honoured in FETCH, so stray or late acks never disturb ir.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            fpc    <= RESET_PC;
            ir     <= '0;
            pc_out <= RESET_PC;
        end else begin
            if ((state == FETCH) && imem_ack) begin
                ir     <= imem_rdata;
                pc_out <= fpc;
                fpc    <= fpc + ADDR_W'(1);
            end else if (accept && !halt && br_taken) begin
                fpc <= br_target;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch
//
// Randomized self-checking bench for ifetch. Every cycle the outputs are
// compared on the falling edge against a transaction-level reference model,
// then new random inputs (memory acks with random wait states, stray acks,
// backpressure, branches, halts, resets) are driven for the next rising edge.
// ---------------------------------------------------------------------------
module tb_ifetch;

    localparam int              AW     = 16;
    localparam logic [AW-1:0]   RPC    = 16'h0000;
    localparam int              PCMASK = (1 << AW) - 1;
    localparam int              NCYC   = 6000;

    logic          clk;
    logic          rst_f;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   ir;
    logic          ir_valid;
    logic          ir_ready;
    logic [AW-1:0] pc_out;
    logic          br_taken;
    logic          br_rel;
    logic [15:0]   br_imm;
    logic          halt;

    int assertCount;
    int failCount;

    // Reference model: which phase of the fetch cycle we are in, plus the
    // architectural values the outputs must show.
    bit          mIdle;
    bit          mReq;
    bit          mHold;
    bit          mHalted;
    int          mFpc;
    int          mPc;
    logic [31:0] mIr;

    ifetch #(
        .ADDR_W   (AW),
        .RESET_PC (RPC)
    ) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .pc_out     (pc_out),
        .br_taken   (br_taken),
        .br_rel     (br_rel),
        .br_imm     (br_imm),
        .halt       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Program image: every word encodes its own address
    function automatic logic [31:0] memWord(input int a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    function automatic logic [15:0] pickImm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0:       return 16'hFFFD;
            1:       return 16'h0040;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            4:       return 16'h0001;
            default: return r[15:0];
        endcase
    endfunction

    task automatic modelReset();
        mIdle   = 1'b1;
        mReq    = 1'b0;
        mHold   = 1'b0;
        mHalted = 1'b0;
        mFpc    = int'(RPC);
        mPc     = int'(RPC);
        mIr     = 32'h0;
    endtask

    // Compare every observable output against the model
    task automatic compareAll(input int cyc);
        checkOutput($sformatf("imem_req@%0d", cyc), 32'(imem_req), 32'(mReq));
        checkOutput($sformatf("ir_valid@%0d", cyc), 32'(ir_valid), 32'(mHold));
        checkOutput($sformatf("imem_addr@%0d", cyc), 32'(imem_addr), 32'(mFpc));
        checkOutput($sformatf("ir@%0d", cyc), ir, mIr);
        checkOutput($sformatf("pc_out@%0d", cyc), 32'(pc_out), 32'(mPc));
    endtask

    // Drive random inputs for the coming rising edge and advance the model
    task automatic applyStimulus(input int cyc);
        logic [31:0] garbage;
        int          target;
        garbage = $urandom;

        if (cyc < 2)
            rst_f = 1'b1;
        else if (mHalted)
            rst_f = ($urandom_range(0, 99) < 4);
        else
            rst_f = ($urandom_range(0, 999) < 4);

        if (mReq) begin
            imem_ack   = ($urandom_range(0, 99) < 40);
            imem_rdata = imem_ack ? memWord(mFpc) : {16'hBAD0, garbage[15:0]};
        end else begin
            imem_ack   = ($urandom_range(0, 99) < 25);
            imem_rdata = {16'hBAD1, garbage[15:0]};
        end
        ir_ready = ($urandom_range(0, 99) < 55);
        br_taken = ($urandom_range(0, 99) < 35);
        br_rel   = ($urandom_range(0, 1) == 1);
        br_imm   = pickImm();
        halt     = ($urandom_range(0, 99) < 3);

        if (rst_f) begin
            modelReset();
        end else if (mIdle) begin
            mIdle = 1'b0;
            mReq  = 1'b1;
        end else if (mReq) begin
            if (imem_ack) begin
                mIr   = memWord(mFpc);
                mPc   = mFpc;
                mFpc  = (mFpc + 1) & PCMASK;
                mReq  = 1'b0;
                mHold = 1'b1;
            end
        end else if (mHold) begin
            if (ir_ready) begin
                mHold = 1'b0;
                if (halt) begin
                    mHalted = 1'b1;
                end else begin
                    if (br_taken) begin
                        if (br_rel)
                            target = mPc + 1 + int'($signed(br_imm));
                        else
                            target = int'(br_imm);
                        mFpc = target & PCMASK;
                    end
                    mReq = 1'b1;
                end
            end
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_f       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        ir_ready    = 1'b0;
        br_taken    = 1'b0;
        br_rel      = 1'b0;
        br_imm      = 16'h0;
        halt        = 1'b0;
        modelReset();
        @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            compareAll(cyc);
            applyStimulus(cyc);
        end

        @(negedge clk);
        compareAll(NCYC);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
